// File: rtl/switch_player.sv
// Plays queued 2-bit symbols as one-hot switch presses: each press is held for
// HOLD_CYC cycles and followed by GAP_CYC cycles with every switch released.
module switch_player #(
    parameter int HOLD_CYC = 2097152,
    parameter int GAP_CYC  = 2097152
) (
    input  logic       CLOCK_50,
    input  logic       reset_n,
    input  logic       sym_valid,
    input  logic [1:0] sym,
    output logic       sym_ready,
    input  logic       abort,
    output logic [3:0] sw,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [21:0] HOLD_LOAD = 22'(HOLD_CYC - 1);
    localparam logic [21:0] GAP_LOAD  = 22'(GAP_CYC - 1);

    logic [1:0]  fifo_mem [0:3];
    logic [1:0]  wr_ptr_reg;
    logic [1:0]  rd_ptr_reg;
    logic [2:0]  count_reg;
    state_t      state_reg;
    logic [21:0] cnt_reg;
    logic [3:0]  sw_reg;

    logic        fifo_empty;
    logic        fifo_full;
    logic        push;
    logic        pop;
    logic [1:0]  head_sym;
    logic [3:0]  head_onehot;

    assign fifo_empty = (count_reg == 3'd0);
    assign fifo_full  = (count_reg == 3'd4);

    // Abort wins over everything, including a symbol offered in the same cycle.
    assign push = sym_valid & ~fifo_full & ~abort;
    assign pop  = ~abort & ~fifo_empty &
                  ((state_reg == IDLE) || ((state_reg == GAP) && (cnt_reg == 22'd0)));

    // Head is read combinationally so a symbol can be played the cycle after it lands.
    assign head_sym = fifo_mem[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_decode
            assign head_onehot[gi] = (head_sym == 2'(gi));
        end
    endgenerate

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= sym;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else if (abort) begin
            wr_ptr_reg <= 2'd0;
            rd_ptr_reg <= 2'd0;
            count_reg  <= 3'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 2'd1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 2'd1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= IDLE;
            cnt_reg   <= 22'd0;
            sw_reg    <= 4'b0000;
        end else if (abort) begin
            state_reg <= IDLE;
            cnt_reg   <= 22'd0;
            sw_reg    <= 4'b0000;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (pop) begin
                        sw_reg    <= head_onehot;
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= PRESS;
                    end
                end
                PRESS: begin
                    if (cnt_reg == 22'd0) begin
                        sw_reg    <= 4'b0000;
                        cnt_reg   <= GAP_LOAD;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg - 22'd1;
                    end
                end
                GAP: begin
                    if (cnt_reg != 22'd0) begin
                        cnt_reg <= cnt_reg - 22'd1;
                    end else if (pop) begin
                        sw_reg    <= head_onehot;
                        cnt_reg   <= HOLD_LOAD;
                        state_reg <= PRESS;
                    end else begin
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    sw_reg    <= 4'b0000;
                    cnt_reg   <= 22'd0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign sw        = sw_reg;
    assign sym_ready = ~fifo_full;
    assign busy      = ~fifo_empty | (state_reg != IDLE);

endmodule

// File: tb/tb_switch_player.sv
// Directed bench for switch_player with HOLD_CYC=3, GAP_CYC=2: press timing,
// queue order and full stall, abort, asynchronous reset and encoder round-trip.
module tb_switch_player;

    logic       clk;
    logic       reset_n;
    logic       sym_valid;
    logic [1:0] sym;
    logic       sym_ready;
    logic       abort;
    logic [3:0] sw;
    logic       busy;

    int n_checks;
    int n_fail;

    switch_player #(
        .HOLD_CYC(3),
        .GAP_CYC (2)
    ) dut (
        .CLOCK_50 (clk),
        .reset_n  (reset_n),
        .sym_valid(sym_valid),
        .sym      (sym),
        .sym_ready(sym_ready),
        .abort    (abort),
        .sw       (sw),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n   = 1'b0;
        abort     = 1'b0;
        sym_valid = 1'b1;
        sym       = 2'b11;
        #2;
        n_checks++;
        if (sw !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_sw: got %b expected 0000", sw);
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b expected 0", busy);
        end
        n_checks++;
        if (sym_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b expected 1", sym_ready);
        end
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_accept: busy got %b expected 0", busy);
        end
        sym_valid = 1'b0;
        #1;
        reset_n = 1'b1;
        tick();
        n_checks++;
        if ({busy, sw} !== 5'b00000) begin
            n_fail++;
            $display("FAIL reset_release: busy,sw got %b expected 00000", {busy, sw});
        end
        $display("reset done");
    endtask

    task automatic test_single;
        logic [3:0] exp_sw [1:6];
        logic       exp_busy [1:6];
        exp_sw   = '{4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0000, 4'b0000};
        exp_busy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        sym_valid = 1'b1;
        sym       = 2'b10;
        tick();
        sym_valid = 1'b0;
        n_checks++;
        if ({busy, sw} !== 5'b10000) begin
            n_fail++;
            $display("FAIL single_push: busy,sw got %b expected 10000", {busy, sw});
        end
        for (int k = 1; k <= 6; k++) begin
            tick();
            n_checks++;
            if (sw !== exp_sw[k]) begin
                n_fail++;
                $display("FAIL single_sw edge %0d: got %b expected %b", k, sw, exp_sw[k]);
            end
            n_checks++;
            if (busy !== exp_busy[k]) begin
                n_fail++;
                $display("FAIL single_busy edge %0d: got %b expected %b", k, busy, exp_busy[k]);
            end
        end
        $display("single symbol 10 played");
    endtask

    // Push 00,01,10,11,01 back to back, then offer 11 while full; period is 5 cycles.
    task automatic test_queue_and_full;
        logic [1:0] seq [0:4];
        logic [3:0] exp_sw;
        logic [1:0] decoded;
        int         idx;
        int         phase;
        seq = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b01};
        for (int k = 0; k <= 26; k++) begin
            if (k < 5) begin
                sym_valid = 1'b1;
                sym       = seq[k];
                n_checks++;
                if (sym_ready !== 1'b1) begin
                    n_fail++;
                    $display("FAIL queue_ready before edge %0d: got %b expected 1", k, sym_ready);
                end
            end else if (k == 5) begin
                sym_valid = 1'b1;
                sym       = 2'b11;
                n_checks++;
                if (sym_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_ready before stall: got %b expected 0", sym_ready);
                end
            end else begin
                sym_valid = 1'b0;
            end
            tick();
            if (k == 5) begin
                n_checks++;
                if (sym_ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_ready after stall: got %b expected 0", sym_ready);
                end
            end
            n_checks++;
            if ($countones(sw) > 1) begin
                n_fail++;
                $display("FAIL onehot edge %0d: sw got %b expected at most one bit", k, sw);
            end
            if (k >= 1 && k <= 25) begin
                idx    = (k - 1) / 5;
                phase  = (k - 1) % 5;
                exp_sw = (phase < 3) ? (4'b0001 << seq[idx]) : 4'b0000;
                n_checks++;
                if (sw !== exp_sw) begin
                    n_fail++;
                    $display("FAIL queue_sw edge %0d: got %b expected %b", k, sw, exp_sw);
                end
                n_checks++;
                if (busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL queue_busy edge %0d: got %b expected 1", k, busy);
                end
                if (phase == 0) begin
                    decoded = {sw[3] | sw[2], sw[1] | sw[3]};
                    n_checks++;
                    if (decoded !== seq[idx]) begin
                        n_fail++;
                        $display("FAIL roundtrip press %0d: got %b expected %b", idx, decoded, seq[idx]);
                    end
                    $display("press %0d sw=%b decoded=%b", idx, sw, decoded);
                end
            end else if (k == 26) begin
                n_checks++;
                if ({busy, sw} !== 5'b00000) begin
                    n_fail++;
                    $display("FAIL queue_drain: busy,sw got %b expected 00000", {busy, sw});
                end
            end
        end
    endtask

    task automatic test_abort;
        sym_valid = 1'b1;
        sym       = 2'b01;
        tick();
        sym = 2'b10;
        tick();
        sym = 2'b11;
        tick();
        n_checks++;
        if ({busy, sw} !== 5'b10010) begin
            n_fail++;
            $display("FAIL abort_setup: busy,sw got %b expected 10010", {busy, sw});
        end
        abort = 1'b1;
        sym   = 2'b00;
        tick();
        abort     = 1'b0;
        sym_valid = 1'b0;
        n_checks++;
        if ({busy, sw, sym_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL abort_flush: busy,sw,ready got %b expected 000001", {busy, sw, sym_ready});
        end
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({busy, sw} !== 5'b00000) begin
                n_fail++;
                $display("FAIL abort_quiet cycle %0d: busy,sw got %b expected 00000", k, {busy, sw});
            end
        end
        $display("abort flushed queue");
    endtask

    task automatic test_async_reset;
        sym_valid = 1'b1;
        sym       = 2'b11;
        tick();
        sym = 2'b00;
        tick();
        sym = 2'b01;
        tick();
        sym_valid = 1'b0;
        n_checks++;
        if ({busy, sw} !== 5'b11000) begin
            n_fail++;
            $display("FAIL areset_setup: busy,sw got %b expected 11000", {busy, sw});
        end
        #3;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, sw, sym_ready} !== 6'b000001) begin
            n_fail++;
            $display("FAIL areset_immediate: busy,sw,ready got %b expected 000001", {busy, sw, sym_ready});
        end
        #1;
        reset_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            tick();
            n_checks++;
            if ({busy, sw} !== 5'b00000) begin
                n_fail++;
                $display("FAIL areset_quiet cycle %0d: busy,sw got %b expected 00000", k, {busy, sw});
            end
        end
        $display("async reset cleared press and queue");
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        reset_n   = 1'b0;
        abort     = 1'b0;
        sym_valid = 1'b0;
        sym       = 2'b00;
        test_reset();
        test_single();
        test_queue_and_full();
        test_abort();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/switch_player.md
SWITCH_PLAYER -- requirements
Module: switch_player

Interface
REQ-001 Parameter HOLD_CYC, default 2097152; number of CLOCK_50 cycles each switch is held high; legal range 1..4194303.
REQ-002 Parameter GAP_CYC, default 2097152; number of CLOCK_50 cycles all switches are held low after each press; legal range 1..4194303.
REQ-003 CLOCK_50  input  1  sole clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous active-low reset.
REQ-005 sym_valid  input  1  a 2-bit symbol is offered on sym this cycle.
REQ-006 sym  input  2  symbol code: 00, 01, 10 or 11.
REQ-007 sym_ready  output  1  the block accepts a symbol this cycle.
REQ-008 abort  input  1  synchronous flush of the queue and any press in progress.
REQ-009 sw  output  4  one-hot switch image, registered; 0000 when no switch is pressed.
REQ-010 busy  output  1  high when the queue is not empty or the state is not IDLE.

Function
REQ-011 Decode SHALL be sym 00->sw 0001, 01->0010, 10->0100, 11->1000, so (sw[3]|sw[2], sw[1]|sw[3]) reproduces sym.
REQ-012 A symbol SHALL be accepted on a rising edge where sym_valid=1 and sym_ready=1 and abort=0.
REQ-013 Accepted symbols SHALL enter a 4-entry FIFO in arrival order; sym_ready SHALL equal NOT full.
REQ-014 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-015 The FSM states SHALL be IDLE, PRESS and GAP, with a 22-bit cycle counter.
REQ-016 IDLE with the FIFO non-empty: at the next edge, pop the head, drive sw to its one-hot value, load counter = HOLD_CYC-1, enter PRESS.
REQ-017 Latency: a symbol pushed at edge N into an empty FIFO while in IDLE SHALL appear on sw at edge N+1.
REQ-018 PRESS: hold sw constant and decrement the counter; at counter 0, set sw=0000, load counter = GAP_CYC-1, enter GAP.
REQ-019 sw SHALL be non-zero for exactly HOLD_CYC cycles per symbol.
REQ-020 GAP: hold sw=0000 and decrement the counter; at counter 0, if the FIFO is non-empty pop and enter PRESS as in REQ-016, else enter IDLE.
REQ-021 Back-to-back symbols SHALL have a period of exactly HOLD_CYC+GAP_CYC cycles.
REQ-022 sw SHALL never have more than one bit set, and every press SHALL be preceded by at least one all-zero cycle after reset or a previous press.
REQ-023 abort=1 at an edge SHALL empty the FIFO, force sw=0000, enter IDLE and clear the counter; a simultaneous sym_valid SHALL be ignored.
REQ-024 A symbol offered while full (sym_ready=0) SHALL be ignored and the FIFO SHALL be unchanged.
REQ-025 busy SHALL fall in the same cycle the FSM enters IDLE with the FIFO empty.

Reset
REQ-026 reset_n=0 SHALL immediately, without a clock, force sw=0000, state=IDLE, counter=0, FIFO empty, sym_ready=1 and busy=0.
REQ-027 Reset asserted mid-PRESS SHALL drop sw to 0000 asynchronously, and queued symbols SHALL be discarded.
REQ-028 After reset_n rises, the first acceptance SHALL occur no earlier than the first rising edge after release.

Verification (HOLD_CYC=3, GAP_CYC=2)
REQ-029 Single symbol: push sym=10 at edge 0 -> sw=0100 on edges 1-3 (3 cycles), 0000 for 2 cycles, then IDLE and busy=0.
REQ-030 Queue order and full: push 00,01,10,11,01 on consecutive cycles -> the 5th push is accepted only after the first pop; sw shows 0001,0010,0100,1000,0010, each period 5 cycles.
REQ-031 Full stall: with the FIFO full, sym_valid=1 sym=11 -> sym_ready=0 and the symbol is not played; occupancy stays 4.
REQ-032 Abort mid-PRESS: with 2 queued and sw=0010, assert abort for 1 cycle -> next edge sw=0000, busy=0, and no further presses.
REQ-033 Async reset: pulse reset_n low between edges during PRESS -> sw=0000 before the next edge, and the FIFO is empty afterward.
REQ-034 Encoder round-trip: feed sw through the 4-to-2 OR encoder -> the decoded codes equal the pushed sequence, and at most one sw bit is high in any cycle.
